// File: rtl/led_disp_pkg.sv
// ---------------------------------------------------------------------------
// led_disp_pkg
// Shared definitions for the debug LED hex display:
//   state_t  - scan controller states (INIT, SCAN)
//   SEG_*    - active-high 7-segment codes, bit order {g,f,e,d,c,b,a}
//   hex7()   - nibble to active-high segment code
// ---------------------------------------------------------------------------
package led_disp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/led_hex_display_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Combinational nibble to 7-segment decoder (active-high codes).
//   nibble - 4-bit hex digit
//   seg    - segments {g,f,e,d,c,b,a}, 1 = lit
// ---------------------------------------------------------------------------
module hex7seg
    import led_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule

// File: rtl/led_hex_display.sv
// ---------------------------------------------------------------------------
// led_hex_display
// Shows the 32-bit debug LED register on a multiplexed 7-segment display as
// hex. A prescaler defines digit slots; the scan FSM steps one digit per
// slot and snapshots the input only at frame boundaries so a frame never
// tears. The tail of every slot is blanked to avoid ghosting.
//   clk_cpu  - clock
//   reset    - asynchronous, active-high
//   value    - value to display
//   freeze   - hold the snapshot at frame boundaries (dp on digit 0 lit)
//   lz_blank - suppress leading zero digits (digit 0 always shown)
//   seg_n    - segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   dp_n     - decimal point, polarity per ACTIVE_LOW
//   an_n     - digit enables, one-hot or all-off, polarity per ACTIVE_LOW
//   shown    - snapshot currently displayed
// ---------------------------------------------------------------------------
module led_hex_display
    import led_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_CYC  = 1024,
    parameter int BLANK_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_cpu,
    input  logic                  reset,
    input  logic [31:0]           value,
    input  logic                  freeze,
    input  logic                  lz_blank,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [31:0]           shown
);

    localparam int CNT_W = $clog2(DIGIT_CYC);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIGIT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(DIGIT_CYC - BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

    // XOR masks applied in the output stage; all-zero for active-high builds.
    localparam logic [6:0]            SEG_INV = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      digit_idx;
    state_t                state;

    logic                  slot_end;
    logic                  blank_win;
    logic [3:0]            nibble;
    logic [6:0]            seg_dec;
    logic                  upper_zero;
    logic                  suppress;
    logic                  digit_on;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign slot_end  = (div_cnt == CNT_LAST);
    assign blank_win = (BLANK_CYC > 0) && (div_cnt >= BLANK_START);

    // Prescaler, scan FSM and frame-boundary snapshot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_idx <= '0;
            state     <= INIT;
            shown     <= '0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) begin
                case (state)
                    INIT: begin
                        // First snapshot is unconditional so the display
                        // never starts frozen on the reset value.
                        shown     <= value;
                        digit_idx <= '0;
                        state     <= SCAN;
                    end
                    default: begin
                        if (digit_idx == IDX_LAST) begin
                            digit_idx <= '0;
                            if (!freeze) begin
                                shown <= value;
                            end
                        end else begin
                            digit_idx <= digit_idx + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Select the nibble of the current digit and decide whether it is a
    // leading zero (this digit and every digit above it are zero).
    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nibble     = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nibble = shown[4*i +: 4];
            end
            if ((IDX_W'(i) >= digit_idx) && (shown[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    assign suppress = lz_blank && (digit_idx != '0) && upper_zero;
    assign digit_on = (state == SCAN) && !blank_win && !suppress;
    assign an_d     = digit_on ? (NUM_DIGITS'(1) << digit_idx) : '0;
    assign seg_d    = digit_on ? seg_dec : SEG_OFF;
    assign dp_d     = digit_on && freeze && (digit_idx == '0);

    // Registered output stage; polarity applied here only.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            seg_n <= SEG_INV;
            dp_n  <= ACTIVE_LOW;
            an_n  <= AN_INV;
        end else begin
            seg_n <= seg_d ^ SEG_INV;
            dp_n  <= dp_d ^ ACTIVE_LOW;
            an_n  <= an_d ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_led_hex_display.sv
// ---------------------------------------------------------------------------
// tb_led_hex_display
// Directed bench for led_hex_display with DIGIT_CYC=8, BLANK_CYC=2: each
// digit slot is 6 lit cycles followed by 2 dark cycles, a frame is 64 cycles.
// An active-high instance shares clock and reset with the main instance.
// ---------------------------------------------------------------------------
module tb_led_hex_display;

    logic        clk_cpu;
    logic        reset;
    logic [31:0] value;
    logic        freeze;
    logic        lz_blank;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic [31:0] shown;

    logic [31:0] value_ah;
    logic [6:0]  seg_ah;
    logic        dp_ah;
    logic [7:0]  an_ah;
    logic [31:0] shown_ah;

    int checks   = 0;
    int failures = 0;

    // Expected active-high codes, packed {d7,...,d0}.
    localparam logic [55:0] SEGS_ZERO = {{7{7'h00}}, 7'h3F};
    localparam logic [55:0] SEGS_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h77, 7'h7C, 7'h39, 7'h5E};
    localparam logic [55:0] SEGS_F00  = {{5{7'h00}}, 7'h71, 7'h3F, 7'h3F};
    localparam logic [55:0] SEGS_DEAD = {7'h5E, 7'h79, 7'h77, 7'h5E,
                                         7'h7C, 7'h79, 7'h79, 7'h71};

    led_hex_display #(
        .NUM_DIGITS (8),
        .DIGIT_CYC  (8),
        .BLANK_CYC  (2),
        .ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .value    (value),
        .freeze   (freeze),
        .lz_blank (lz_blank),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .shown    (shown)
    );

    led_hex_display #(
        .NUM_DIGITS (8),
        .DIGIT_CYC  (8),
        .BLANK_CYC  (2),
        .ACTIVE_LOW (1'b0)
    ) u_dut_ah (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .value    (value_ah),
        .freeze   (1'b0),
        .lz_blank (1'b1),
        .seg_n    (seg_ah),
        .dp_n     (dp_ah),
        .an_n     (an_ah),
        .shown    (shown_ah)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Check digit slots first..last of the current frame, one negedge per
    // cycle. Slot cycles 0..5 are lit (unless suppressed), 6..7 are dark.
    task automatic run_slots(input string tag, input int first, input int last,
                             input logic [55:0] segs, input logic [7:0] sup,
                             input logic dp0);
        logic       active;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int d = first; d <= last; d++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk_cpu);
                active  = (c < 6) && !sup[d];
                exp_an  = active ? ~(8'h01 << d) : 8'hFF;
                exp_seg = ~segs[7*d +: 7];
                exp_dp  = !(active && dp0 && (d == 0));
                checks++;
                if (an_n !== exp_an) begin
                    failures++;
                    $display("FAIL %s an_n digit %0d cyc %0d: got %h want %h",
                             tag, d, c, an_n, exp_an);
                end
                if (active) begin
                    checks++;
                    if (seg_n !== exp_seg) begin
                        failures++;
                        $display("FAIL %s seg_n digit %0d cyc %0d: got %h want %h",
                                 tag, d, c, seg_n, exp_seg);
                    end
                end
                checks++;
                if (dp_n !== exp_dp) begin
                    failures++;
                    $display("FAIL %s dp_n digit %0d cyc %0d: got %b want %b",
                             tag, d, c, dp_n, exp_dp);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_cpu);
        reset = 1'b1;
        @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    // The INIT slot: 8 cycles with all anodes off.
    task automatic wait_init(input string tag);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_cpu);
            checks++;
            if (an_n !== 8'hFF) begin
                failures++;
                $display("FAIL %s init an_n cyc %0d: got %h want ff", tag, c, an_n);
            end
        end
    endtask

    task automatic test_reset();
        value    = 32'h0;
        value_ah = 32'h8;
        freeze   = 1'b0;
        lz_blank = 1'b1;
        reset    = 1'b1;
        #1;
        checks++;
        if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset outputs: got an=%h seg=%h dp=%b want ff 7f 1",
                     an_n, seg_n, dp_n);
        end
        checks++;
        if (shown !== 32'h0) begin
            failures++;
            $display("FAIL reset shown: got %h want 00000000", shown);
        end
        checks++;
        if ({an_ah, seg_ah, dp_ah} !== {8'h00, 7'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset active-high outputs: got an=%h seg=%h dp=%b want 00 00 0",
                     an_ah, seg_ah, dp_ah);
        end
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        wait_init("zero");
        run_slots("zero", 0, 7, SEGS_ZERO, 8'hFE, 1'b0);
    endtask

    task automatic test_scan_and_midframe();
        value    = 32'h1234ABCD;
        lz_blank = 1'b0;
        pulse_reset();
        wait_init("scan");
        run_slots("scan", 0, 3, SEGS_1234, 8'h00, 1'b0);
        checks++;
        if (shown !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL scan shown: got %h want 1234abcd", shown);
        end
        value    = 32'h00000F00;
        lz_blank = 1'b1;
        run_slots("midframe", 4, 7, SEGS_1234, 8'h00, 1'b0);
        checks++;
        if (shown !== 32'h00000F00) begin
            failures++;
            $display("FAIL boundary shown: got %h want 00000f00", shown);
        end
        run_slots("f00", 0, 7, SEGS_F00, 8'hF8, 1'b0);
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        value  = 32'hDEADBEEF;
        for (int f = 0; f < 3; f++) begin
            run_slots("frozen", 0, 7, SEGS_F00, 8'hF8, 1'b1);
            checks++;
            if (shown !== 32'h00000F00) begin
                failures++;
                $display("FAIL frozen shown frame %0d: got %h want 00000f00", f, shown);
            end
        end
        freeze = 1'b0;
        run_slots("unfreeze", 0, 7, SEGS_F00, 8'hF8, 1'b0);
        checks++;
        if (shown !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL unfreeze shown: got %h want deadbeef", shown);
        end
        run_slots("dead", 0, 7, SEGS_DEAD, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_slot();
        // Frame start plus 29 cycles lands on digit 3 with div_cnt=5.
        repeat (29) @(negedge clk_cpu);
        reset = 1'b1;
        #1;
        checks++;
        if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL midslot reset outputs: got an=%h seg=%h dp=%b want ff 7f 1",
                     an_n, seg_n, dp_n);
        end
        checks++;
        if (shown !== 32'h0) begin
            failures++;
            $display("FAIL midslot reset shown: got %h want 00000000", shown);
        end
        @(negedge clk_cpu);
        reset = 1'b0;
        wait_init("midslot");
        run_slots("midslot", 0, 0, SEGS_DEAD, 8'h00, 1'b0);
        checks++;
        if (shown !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL midslot reload shown: got %h want deadbeef", shown);
        end
    endtask

    task automatic test_active_high();
        logic [7:0] exp_an;
        pulse_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_cpu);
            exp_an = (c >= 8 && c < 14) ? 8'h01 : 8'h00;
            checks++;
            if (an_ah !== exp_an) begin
                failures++;
                $display("FAIL active-high an cyc %0d: got %h want %h", c, an_ah, exp_an);
            end
            if (exp_an != 8'h00) begin
                checks++;
                if ({seg_ah, dp_ah} !== {7'h7F, 1'b0}) begin
                    failures++;
                    $display("FAIL active-high seg/dp cyc %0d: got %h %b want 7f 0",
                             c, seg_ah, dp_ah);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_and_midframe();
        test_freeze();
        test_reset_mid_slot();
        test_active_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_hex_display.md
Name: led_hex_display

Overview:
- Downstream consumer of the memory controller's debug LED register.
- Takes the 32-bit value the CPU stores to the debug LED address and drives a multiplexed 8-digit 7-segment display as hexadecimal.
- Provides a prescaled digit scan, frame-boundary snapshotting (no tearing), anti-ghost blanking, leading-zero suppression and a freeze input driven from a board switch.

Parameters:
- NUM_DIGITS, 8: number of hex digits. Legal range 1..8; digit i shows nibble value[4i+3:4i].
- DIGIT_CYC, 1024: clk_cpu cycles each digit is selected. Must be >= 4 and > BLANK_CYC.
- BLANK_CYC, 16: cycles at the end of each digit slot with all anodes off (anti-ghosting).
- ACTIVE_LOW, 1: 1 means seg_n, dp_n and an_n are driven active-low; 0 means active-high.

Ports:
- clk_cpu, input, 1: single clock.
- reset, input, 1: asynchronous, active-high.
- value, input, 32: value to display; connected to dbg_led_q.
- freeze, input, 1: 1 means the snapshot is not updated at frame boundaries.
- lz_blank, input, 1: 1 enables leading-zero suppression.
- seg_n, output, 7: segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- dp_n, output, 1: decimal point, polarity per ACTIVE_LOW.
- an_n, output, NUM_DIGITS: digit enables, one-hot or all-off, polarity per ACTIVE_LOW.
- shown, output, 32: snapshot currently displayed.

Behaviour:
- All outputs are registered. Internal logic is active-high; the final output stage inverts when ACTIVE_LOW=1.
- Reset values:
  - div_cnt=0, digit_idx=0, state=INIT, shown=0.
  - All segments, dp and anodes inactive (ACTIVE_LOW=1 gives seg_n=7'h7F, dp_n=1, an_n all ones).
- Prescaler div_cnt:
  - Counts 0..DIGIT_CYC-1 and wraps to 0.
  - slot_end is asserted when div_cnt==DIGIT_CYC-1.
  - blank_win is asserted when div_cnt>=DIGIT_CYC-BLANK_CYC.
- States:
  - INIT: anodes off for one full slot. On slot_end, load shown<=value (regardless of freeze), set digit_idx=0, go to SCAN.
  - SCAN: on slot_end, digit_idx increments. When digit_idx==NUM_DIGITS-1 it wraps to 0 (frame boundary).
  - At the frame boundary, shown<=value if freeze==0; otherwise shown is held.
  - value changes mid-frame never alter the frame in progress.
- Outputs in SCAN, registered, so they reflect div_cnt/digit_idx from the previous cycle (1-cycle latency):
  - an: one-hot bit digit_idx, except all-off during blank_win or when the digit is suppressed.
  - seg: hex7 decode of nibble shown[4*digit_idx+3 -: 4]. Active-high codes:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Suppression: digit i>0 is suppressed iff lz_blank=1 and shown[4*NUM_DIGITS-1:4i]==0. Digit 0 is never suppressed, so the value 0 shows a single "0".
  - dp: asserted only on digit 0 while freeze==1 (frozen indicator); otherwise off.
- Simultaneous events:
  - freeze deasserting in the same cycle as a frame boundary: that boundary loads (freeze is sampled at the boundary cycle).
  - reset mid-slot: immediate asynchronous return to the reset values and INIT.
- NUM_DIGITS<8: upper bits of value are ignored for display, but shown still latches all 32 bits.

Decomposition:
- Shared package led_disp_pkg:
  - typedef of state enum {INIT, SCAN}.
  - localparams SEG_0..SEG_F (7-bit active-high codes) and SEG_OFF=7'h00.
  - function hex7(nibble) returning the code.
- One natural sub-module: hex7seg, a combinational nibble-to-segments decoder instantiated once on the muxed nibble.
- Prescaler, scan FSM, snapshot and output registers all live in led_hex_display.

Test Plan:
- Reset release with value=32'h0, DIGIT_CYC=8, BLANK_CYC=2 -> an_n all ones for the first 8+1 cycles; then an_n=8'hFE, seg_n=~7'h3F; digits 1..7 stay dark (lz_blank=1).
- value=32'h1234ABCD, lz_blank=0 -> after INIT, digits 0..7 show in sequence d, C, b, A, 4, 3, 2, 1 (seg active-high 5E, 39, 7C, 77, 66, 4F, 5B, 06); each digit's anode is low for 6 cycles, then all-off for 2.
- Change value to 32'h00000F00 mid-frame -> the current frame still shows 1234ABCD; the next frame shows F00 with digits 3..7 suppressed (lz_blank=1) and digit 1 showing "0".
- freeze=1, then change value to 32'hDEADBEEF -> shown stays at the old value across 3 frame boundaries and dp_n=0 only while digit 0 is active. Drop freeze -> shown=DEADBEEF at the next boundary.
- Assert reset at div_cnt=5 of digit 3 -> same cycle: an_n all ones, shown=0, state INIT; a full INIT slot elapses before any anode is enabled.
- ACTIVE_LOW=0 build with value=32'h8 -> an=8'h01 on digit 0 with seg=7'h7F; all-off anodes read 8'h00.
